aes_dec_key_sched_128: RTL and testbench

Iterative AES-128 decryption key scheduler. It accepts the cipher key, or the final round key directly, and runs the forward schedule to rk10 if needed. It then walks the schedule backwards and emits round keys rk10, rk9 … rk0 in decryption order over a valid/ready stream. It sits between key load and the iterative decrypt datapath and holds one 128-bit register instead of an 11-entry key store.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_key_expand_128.sv | 38 +++
 rtl/aes_key_unexpand_128.sv | 38 +++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_dec_key_sched_128.sv | 111 +++++++++++
 tb/tb_aes_dec_key_sched_128.sv | 361 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key type, scheduler state encoding,
// Rcon lookup and the GF(2^8) multiply used by the S-box.
package aes_pkg;

   localparam int NR = 10;

   typedef logic [127:0] key128_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   // Round constant for rounds 1..10; any other index yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_key_expand_128.sv
// One forward AES-128 key expansion step: rk[r-1] -> rk[r] using Rcon[r].
module aes_key_expand_128
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3, rot_w, sub_w, temp, n0, n1, n2, n3;

   assign w0    = key_in[127:96];
   assign w1    = key_in[95:64];
   assign w2    = key_in[63:32];
   assign w3    = key_in[31:0];
   assign rot_w = {w3[23:0], w3[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .in_byte  (rot_w[gi*8 +: 8]),
            .out_byte (sub_w[gi*8 +: 8])
         );
      end
   endgenerate

   // Chained word XORs of the standard expansion.
   always_comb begin
      temp    = sub_w ^ {rcon, 24'h000000};
      n0      = w0 ^ temp;
      n1      = w1 ^ n0;
      n2      = w2 ^ n1;
      n3      = w3 ^ n2;
      key_out = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_key_unexpand_128.sv
// One inverse AES-128 key expansion step: rk[r] -> rk[r-1] using Rcon[r].
// w3 of the previous key is recovered first because w0 depends on it.
module aes_key_unexpand_128
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] key_out
);

   logic [31:0] w0p, w1p, w2p, w3p, p1, p2, p3, rot_w, sub_w, p0;

   assign w0p   = key_in[127:96];
   assign w1p   = key_in[95:64];
   assign w2p   = key_in[63:32];
   assign w3p   = key_in[31:0];
   assign p3    = w3p ^ w2p;
   assign p2    = w2p ^ w1p;
   assign p1    = w1p ^ w0p;
   assign rot_w = {p3[23:0], p3[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .in_byte  (rot_w[gi*8 +: 8]),
            .out_byte (sub_w[gi*8 +: 8])
         );
      end
   endgenerate

   // Undo the w0 update using the recovered w3.
   always_comb begin
      p0      = w0p ^ sub_w ^ {rcon, 24'h000000};
      key_out = {p0, p1, p2, p3};
   end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse (x^254) followed by the affine map.
// Computed rather than tabulated so it stays pure combinational logic.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

   // Square-and-multiply chain to x^254; zero maps to zero naturally.
   always_comb begin
      x2   = gf_mul(in_byte, in_byte);
      x3   = gf_mul(x2, in_byte);
      x6   = gf_mul(x3, x3);
      x7   = gf_mul(x6, in_byte);
      x14  = gf_mul(x7, x7);
      x15  = gf_mul(x14, in_byte);
      x30  = gf_mul(x15, x15);
      x31  = gf_mul(x30, in_byte);
      x62  = gf_mul(x31, x31);
      x63  = gf_mul(x62, in_byte);
      x126 = gf_mul(x63, x63);
      x127 = gf_mul(x126, in_byte);
      inv  = gf_mul(x127, x127);
      out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_dec_key_sched_128.sv
// Iterative AES-128 decryption key scheduler. A single key register is rolled
// forward to rk10 (unless rk10 is loaded directly), then rolled backwards,
// presenting rk10..rk0 on a valid/ready stream.
module aes_dec_key_sched_128
   import aes_pkg::*;
#(
   parameter int NR = aes_pkg::NR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   input  logic         key_is_last,
   input  logic         abort,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         busy
);

   localparam logic [3:0] LAST_IDX = 4'(NR);

   state_t  state_q, state_d;
   key128_t key_q, key_d;
   logic [3:0] cnt_q, cnt_d;
   key128_t fwd_key, inv_key;

   aes_key_expand_128 u_expand (
      .key_in  (key_q),
      .rcon    (rcon(cnt_q + 4'd1)),
      .key_out (fwd_key)
   );

   aes_key_unexpand_128 u_unexpand (
      .key_in  (key_q),
      .rcon    (rcon(cnt_q)),
      .key_out (inv_key)
   );

   // State, key and round-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; abort overrides everything but leaves key_q untouched.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (key_valid) begin
               key_d = key_in;
               if (key_is_last) begin
                  cnt_d   = LAST_IDX;
                  state_d = ST_EMIT;
               end else begin
                  cnt_d   = 4'd0;
                  state_d = ST_FWD;
               end
            end
         end
         ST_FWD: begin
            key_d = fwd_key;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_IDX - 4'd1) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (rk_ready) begin
               if (cnt_q == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  key_d = inv_key;
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         key_d   = key_q;
         cnt_d   = 4'd0;
      end
   end

   // Outputs decode from registers only, so they hold steady during a stall.
   always_comb begin
      key_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      rk_valid  = (state_q == ST_EMIT);
      rk_out    = rk_valid ? key_q : '0;
      rk_idx    = rk_valid ? cnt_q : 4'd0;
      rk_last   = rk_valid && (cnt_q == 4'd0);
   end

endmodule

// File: tb/tb_aes_dec_key_sched_128.sv
// Bench for aes_dec_key_sched_128: a log/antilog-table software key schedule
// fills a scoreboard queue; round keys are popped and compared on handshakes.
module tb_aes_dec_key_sched_128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_valid = 1'b0;
   logic         key_is_last = 1'b0;
   logic         abort = 1'b0;
   logic         rk_ready = 1'b0;
   logic [127:0] key_in = '0;
   logic         key_ready, rk_valid, rk_last, busy;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [127:0] key;
      logic [3:0]   idx;
   } exp_t;

   exp_t         sb_q[$];
   logic [7:0]   sbox_tb [0:255];
   logic [127:0] model_rk [0:10];
   logic [7:0]   rcon_tb [1:10];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_dec_key_sched_128 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_in      (key_in),
      .key_is_last (key_is_last),
      .abort       (abort),
      .rk_valid    (rk_valid),
      .rk_ready    (rk_ready),
      .rk_out      (rk_out),
      .rk_idx      (rk_idx),
      .rk_last     (rk_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // S-box via generator-3 exp/log tables and the affine map.
   task automatic build_sbox();
      logic [7:0] ex [0:255];
      int         lg [0:255];
      logic [7:0] v, inv;
      v = 8'h01;
      for (int i = 0; i < 255; i++) begin
         ex[i] = v;
         lg[v] = i;
         v = v ^ {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
      end
      for (int x = 0; x < 256; x++) begin
         if (x == 0) inv = 8'h00;
         else inv = ex[(255 - lg[x]) % 255];
         sbox_tb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      rcon_tb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
   endfunction

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w0, w1, w2, w3, t;
      model_rk[0] = k;
      for (int r = 1; r <= 10; r++) begin
         {w0, w1, w2, w3} = model_rk[r-1];
         t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_tb[r], 24'h0};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         model_rk[r] = {w0, w1, w2, w3};
      end
   endtask

   task automatic push_expected();
      exp_t e;
      for (int r = 10; r >= 0; r--) begin
         e.key = model_rk[r];
         e.idx = 4'(r);
         sb_q.push_back(e);
      end
   endtask

   task automatic load_key(input logic [127:0] k, input logic last);
      @(negedge clk);
      key_in      = k;
      key_is_last = last;
      key_valid   = 1'b1;
      @(posedge clk);
      #1;
      key_valid   = 1'b0;
   endtask

   // Counts edges until rk_valid; busy/key_ready are checked every FWD cycle.
   task automatic wait_valid(input int exp_edges, input string tag);
      int edges = 0;
      @(negedge clk);
      while (!rk_valid && edges < 40) begin
         n_cmp++;
         if (key_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s fwd_flags: key_ready=%b busy=%b, required 0/1", tag, key_ready, busy);
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      n_cmp++;
      if (rk_valid !== 1'b1 || edges != exp_edges) begin
         n_err++;
         $display("FAIL %s latency: rk_valid=%b after %0d edges, required 1 after %0d", tag, rk_valid, edges, exp_edges);
      end
   endtask

   // Drives rk_ready at duty% and pops/compares the scoreboard on handshakes.
   task automatic consume(input int duty, input int n_take, input string tag);
      int           taken = 0;
      int           cyc = 0;
      logic         stalled = 1'b0;
      logic [127:0] p_out = '0;
      logic [3:0]   p_idx = '0;
      exp_t         e;
      while (taken < n_take && sb_q.size() > 0 && cyc < 2000) begin
         @(negedge clk);
         rk_ready = ($urandom_range(99) < 32'(duty));
         if (stalled) begin
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_out !== p_out || rk_idx !== p_idx) begin
               n_err++;
               $display("FAIL %s stall_hold: valid=%b idx=%0d out=%h, required 1 %0d %h", tag, rk_valid, rk_idx, rk_out, p_idx, p_out);
            end
         end
         if (rk_valid && rk_ready) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (rk_out !== e.key || rk_idx !== e.idx || rk_last !== (e.idx == 4'd0)) begin
               n_err++;
               $display("FAIL %s rk: got idx=%0d last=%b %h, required idx=%0d last=%b %h", tag, rk_idx, rk_last, rk_out, e.idx, (e.idx == 4'd0), e.key);
            end else begin
               $display("%s rk%0d = %h", tag, rk_idx, rk_out);
            end
            taken++;
         end
         stalled = rk_valid && !rk_ready;
         p_out   = rk_out;
         p_idx   = rk_idx;
         cyc++;
      end
      n_cmp++;
      if (taken < n_take) begin
         n_err++;
         $display("FAIL %s stream_count: got %0d keys, required %0d", tag, taken, n_take);
      end
      @(posedge clk);
      #1;
      rk_ready = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      n_cmp++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle: key_ready=%b rk_valid=%b busy=%b, required 1/0/0", tag, key_ready, rk_valid, busy);
      end
   endtask

   task automatic check_reset_values(input string tag);
      n_cmp++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 ||
          rk_idx !== 4'd0 || rk_last !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s reset_vals: ready=%b valid=%b out=%h idx=%0d last=%b busy=%b, required 1 0 0 0 0 0",
                  tag, key_ready, rk_valid, rk_out, rk_idx, rk_last, busy);
      end
   endtask

   task automatic test_reset();
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("post_reset");
      $display("reset checked");
   endtask

   task automatic test_fips_forward();
      model_expand(FIPS_KEY);
      push_expected();
      load_key(FIPS_KEY, 1'b0);
      wait_valid(10, "fips");
      n_cmp++;
      if (rk_out !== FIPS_RK10 || rk_idx !== 4'd10) begin
         n_err++;
         $display("FAIL fips rk10_const: got %0d %h, required 10 %h", rk_idx, rk_out, FIPS_RK10);
      end
      consume(100, 11, "fips");
      @(negedge clk);
      check_idle("fips");
   endtask

   task automatic test_key_is_last();
      model_expand(FIPS_KEY);
      push_expected();
      load_key(FIPS_RK10, 1'b1);
      wait_valid(0, "last");
      consume(100, 11, "last");
      @(negedge clk);
      check_idle("last");
   endtask

   task automatic test_random_ready();
      logic [127:0] k;
      for (int t = 0; t < 2; t++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         model_expand(k);
         push_expected();
         load_key(k, 1'b0);
         wait_valid(10, "rand");
         consume(30, 11, "rand");
      end
   endtask

   task automatic test_abort();
      logic found = 1'b0;
      load_key(FIPS_KEY, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check_idle("abort_fwd");
      // abort together with a load request: the load is dropped
      key_in    = FIPS_KEY;
      key_valid = 1'b1;
      abort     = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      abort     = 1'b0;
      @(negedge clk);
      check_idle("abort_load");
      load_key(FIPS_RK10, 1'b1);
      rk_ready = 1'b1;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (rk_valid && rk_idx == 4'd7) begin
            found    = 1'b1;
            rk_ready = 1'b0;
            abort    = 1'b1;
         end
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL abort_emit reach_idx7: got found=0, required 1");
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check_idle("abort_emit");
      model_expand(FIPS_KEY);
      push_expected();
      load_key(FIPS_KEY, 1'b0);
      wait_valid(10, "after_abort");
      consume(100, 11, "after_abort");
   endtask

   task automatic test_async_reset();
      model_expand(FIPS_KEY);
      push_expected();
      load_key(FIPS_KEY, 1'b0);
      // load requests while busy must be ignored
      @(negedge clk);
      key_in    = {4{32'hdeadbeef}};
      key_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      key_valid = 1'b0;
      wait_valid(7, "busy_load");
      consume(100, 4, "pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("after_async");
   endtask

   task automatic test_back_to_back();
      model_expand(FIPS_KEY);
      push_expected();
      load_key(FIPS_KEY, 1'b0);
      wait_valid(10, "b2b_a");
      key_in      = 128'h0;
      key_is_last = 1'b0;
      key_valid   = 1'b1;
      consume(100, 11, "b2b_a");
      @(negedge clk);
      check_idle("b2b_gap");
      model_expand(128'h0);
      push_expected();
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      wait_valid(10, "b2b_b");
      n_cmp++;
      if (rk_out !== ZERO_RK10) begin
         n_err++;
         $display("FAIL b2b rk10_const: got %h, required %h", rk_out, ZERO_RK10);
      end
      consume(100, 11, "b2b_b");
      @(negedge clk);
      check_idle("b2b_end");
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_forward();
      test_key_is_last();
      test_random_ready();
      test_abort();
      test_async_reset();
      test_back_to_back();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_left: got %0d entries, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
